// File: rtl/fight_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fight_hit_arbiter
// Brief    : Frame-rate punch arbiter with alternating priority and range
//            check, driving a decaying, wall-clamped knockback on the victim.
//            Optional macro FIGHT_ARB_COOLDOWN_EN adds a post-knockback lockout.
// Revision : 1.0 - initial release
// ============================================================================
module fight_hit_arbiter #(
  parameter int REACH       = 40,
  parameter int KB_START    = 9,
  parameter int KB_END      = 4,
  parameter int COOLDOWN    = 8,
  parameter int BOUND_X_MIN = 7,
  parameter int BOUND_X_MAX = 632
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               frame_tick,
  input  logic               P1_Punch,
  input  logic               P2_Punch,
  input  logic signed [31:0] P1_X,
  input  logic signed [31:0] P2_X,
  output logic signed [31:0] P1_X_Motion,
  output logic signed [31:0] P2_X_Motion,
  output logic               P1_Hit,
  output logic               P2_Hit,
  output logic               busy
);

  localparam logic [7:0]         c_KB_START  = 8'(KB_START);
  localparam logic [7:0]         c_KB_END    = 8'(KB_END);
  localparam logic signed [31:0] c_REACH     = 32'(REACH);
  localparam logic signed [31:0] c_BOUND_MIN = 32'(BOUND_X_MIN);
  localparam logic signed [31:0] c_BOUND_MAX = 32'(BOUND_X_MAX);

`ifdef FIGHT_ARB_COOLDOWN_EN
  localparam logic [7:0] c_COOLDOWN = 8'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KNOCK = 2'd1,
    ST_COOL  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KNOCK = 2'd1
  } state_t;
`endif

  // Punch edge detection
  logic r_prev1, r_prev2;
  logic r_pend1, r_pend2;
  logic w_pend1_eff, w_pend2_eff;

  // FSM / knockback context (victim: 0 = P1, 1 = P2; dir: 1 = +X, 0 = -X)
  state_t            r_state, w_state_nx;
  logic              r_victim, w_victim_nx;
  logic              r_dir, w_dir_nx;
  logic [7:0]        r_speed, w_speed_nx;
  logic              r_final, w_final_nx;
  logic              r_prio, w_prio_nx;
  logic signed [31:0] r_p1_mot, w_p1_mot_nx;
  logic signed [31:0] r_p2_mot, w_p2_mot_nx;
  logic              r_p1_hit, w_p1_hit_nx;
  logic              r_p2_hit, w_p2_hit_nx;
`ifdef FIGHT_ARB_COOLDOWN_EN
  logic [7:0]        r_cnt, w_cnt_nx;
`endif

  // Arbitration
  logic signed [31:0] w_dx, w_adx;
  logic               w_in_reach;
  logic               w_cand1, w_cand2;
  logic               w_grant1, w_grant2;
  logic               w_new_victim, w_new_dir;
  logic signed [31:0] w_new_vx, w_new_ax;

  // Motion rule
  logic               w_rule_victim, w_rule_dir;
  logic [7:0]         w_rule_speed;
  logic signed [31:0] w_rule_vx;
  logic signed [31:0] w_wd_raw, w_wd, w_spd32, w_mag;
  logic signed [31:0] w_rule_mot;
  logic               w_rule_fin;

  // --------------------------------------------------------------------------
  // A rising edge in the tick cycle still counts toward that tick.
  assign w_pend1_eff = r_pend1 | (P1_Punch & ~r_prev1);
  assign w_pend2_eff = r_pend2 | (P2_Punch & ~r_prev2);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_prev1 <= 1'b1;
      r_prev2 <= 1'b1;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
    end else begin
      r_prev1 <= P1_Punch;
      r_prev2 <= P2_Punch;
      r_pend1 <= frame_tick ? 1'b0 : w_pend1_eff;
      r_pend2 <= frame_tick ? 1'b0 : w_pend2_eff;
    end
  end

  // --------------------------------------------------------------------------
  assign w_dx       = P1_X - P2_X;
  assign w_adx      = (w_dx < 32'sd0) ? -w_dx : w_dx;
  assign w_in_reach = (w_adx <= c_REACH);
  assign w_cand1    = w_pend1_eff & w_in_reach;
  assign w_cand2    = w_pend2_eff & w_in_reach;
  assign w_grant1   = w_cand1 & (~w_cand2 | ~r_prio);
  assign w_grant2   = w_cand2 & (~w_cand1 | r_prio);

  assign w_new_victim = w_grant1;
  assign w_new_vx     = w_new_victim ? P2_X : P1_X;
  assign w_new_ax     = w_new_victim ? P1_X : P2_X;
  // Coincident players: P1 is pushed left, P2 right.
  assign w_new_dir    = (w_new_vx > w_new_ax) |
                        ((w_new_vx == w_new_ax) & w_new_victim);

  // --------------------------------------------------------------------------
  // One motion-rule datapath, fed by the fresh hit in IDLE or the held
  // context with the decremented speed in KNOCK.
  assign w_rule_victim = (r_state == ST_IDLE) ? w_new_victim : r_victim;
  assign w_rule_dir    = (r_state == ST_IDLE) ? w_new_dir    : r_dir;
  assign w_rule_speed  = (r_state == ST_IDLE) ? c_KB_START   : (r_speed - 8'd1);
  assign w_rule_vx     = w_rule_victim ? P2_X : P1_X;

  assign w_wd_raw   = w_rule_dir ? (c_BOUND_MAX - w_rule_vx) : (w_rule_vx - c_BOUND_MIN);
  assign w_wd       = (w_wd_raw < 32'sd0) ? 32'sd0 : w_wd_raw;
  assign w_spd32    = $signed({24'd0, w_rule_speed});
  assign w_mag      = (w_wd < w_spd32) ? w_wd : w_spd32;
  assign w_rule_fin = (w_wd < w_spd32) | (w_rule_speed == c_KB_END);
  assign w_rule_mot = w_rule_dir ? w_mag : -w_mag;

  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nx  = r_state;
    w_victim_nx = r_victim;
    w_dir_nx    = r_dir;
    w_speed_nx  = r_speed;
    w_final_nx  = r_final;
    w_prio_nx   = r_prio;
    w_p1_mot_nx = r_p1_mot;
    w_p2_mot_nx = r_p2_mot;
    w_p1_hit_nx = 1'b0;
    w_p2_hit_nx = 1'b0;
`ifdef FIGHT_ARB_COOLDOWN_EN
    w_cnt_nx    = r_cnt;
`endif

    if (frame_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant1 | w_grant2) begin
            w_state_nx  = ST_KNOCK;
            w_victim_nx = w_new_victim;
            w_dir_nx    = w_new_dir;
            w_speed_nx  = c_KB_START;
            w_final_nx  = w_rule_fin;
            w_p1_hit_nx = w_grant1;
            w_p2_hit_nx = w_grant2;
            w_prio_nx   = w_grant1;
            w_p1_mot_nx = w_new_victim ? 32'sd0 : w_rule_mot;
            w_p2_mot_nx = w_new_victim ? w_rule_mot : 32'sd0;
          end
        end

        ST_KNOCK: begin
          if (r_final) begin
            w_p1_mot_nx = 32'sd0;
            w_p2_mot_nx = 32'sd0;
`ifdef FIGHT_ARB_COOLDOWN_EN
            w_state_nx  = ST_COOL;
            w_cnt_nx    = c_COOLDOWN;
`else
            w_state_nx  = ST_IDLE;
`endif
          end else begin
            w_speed_nx  = w_rule_speed;
            w_final_nx  = w_rule_fin;
            w_p1_mot_nx = r_victim ? 32'sd0 : w_rule_mot;
            w_p2_mot_nx = r_victim ? w_rule_mot : 32'sd0;
          end
        end

`ifdef FIGHT_ARB_COOLDOWN_EN
        ST_COOL: begin
          // A zero COOLDOWN still spends one lockout frame rather than wrapping.
          w_cnt_nx = (r_cnt == 8'd0) ? 8'd0 : (r_cnt - 8'd1);
          if (r_cnt <= 8'd1) begin
            w_state_nx = ST_IDLE;
          end
        end
`endif

        default: begin
          w_state_nx  = ST_IDLE;
          w_p1_mot_nx = 32'sd0;
          w_p2_mot_nx = 32'sd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_victim <= 1'b0;
      r_dir    <= 1'b0;
      r_speed  <= 8'd0;
      r_final  <= 1'b0;
      r_prio   <= 1'b0;
      r_p1_mot <= 32'sd0;
      r_p2_mot <= 32'sd0;
      r_p1_hit <= 1'b0;
      r_p2_hit <= 1'b0;
`ifdef FIGHT_ARB_COOLDOWN_EN
      r_cnt    <= 8'd0;
`endif
    end else begin
      r_state  <= w_state_nx;
      r_victim <= w_victim_nx;
      r_dir    <= w_dir_nx;
      r_speed  <= w_speed_nx;
      r_final  <= w_final_nx;
      r_prio   <= w_prio_nx;
      r_p1_mot <= w_p1_mot_nx;
      r_p2_mot <= w_p2_mot_nx;
      r_p1_hit <= w_p1_hit_nx;
      r_p2_hit <= w_p2_hit_nx;
`ifdef FIGHT_ARB_COOLDOWN_EN
      r_cnt    <= w_cnt_nx;
`endif
    end
  end

  assign P1_X_Motion = r_p1_mot;
  assign P2_X_Motion = r_p2_mot;
  assign P1_Hit      = r_p1_hit;
  assign P2_Hit      = r_p2_hit;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fight_hit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fight_hit_arbiter
// Brief    : Directed + randomized bench for fight_hit_arbiter with a
//            frame-level behavioural model (honours FIGHT_ARB_COOLDOWN_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fight_hit_arbiter;

  localparam int REACH = 40;
  localparam int KB_S  = 9;
  localparam int KB_E  = 4;
  localparam int BMIN  = 7;
  localparam int BMAX  = 632;
`ifdef FIGHT_ARB_COOLDOWN_EN
  localparam int LOCK_FRAMES = 8;
`else
  localparam int LOCK_FRAMES = 0;
`endif

  logic               clk = 1'b0;
  logic               Reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic               P1_Punch = 1'b0;
  logic               P2_Punch = 1'b0;
  logic signed [31:0] P1_X = 32'sd100;
  logic signed [31:0] P2_X = 32'sd130;
  logic signed [31:0] P1_X_Motion, P2_X_Motion;
  logic               P1_Hit, P2_Hit, busy;

  int n_cmp = 0;
  int n_bad = 0;

  fight_hit_arbiter dut (
    .clk        (clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .P1_Punch   (P1_Punch),
    .P2_Punch   (P2_Punch),
    .P1_X       (P1_X),
    .P2_X       (P2_X),
    .P1_X_Motion(P1_X_Motion),
    .P2_X_Motion(P2_X_Motion),
    .P1_Hit     (P1_Hit),
    .P2_Hit     (P2_Hit),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (frame-level) ----------------
  bit m_live = 0;
  bit m_prev1, m_prev2, m_pend1, m_pend2;
  bit m_prio2;             // 1: P2 wins a tie
  bit m_knock, m_last, m_vic2;
  int m_lock, m_spd, m_dir;
  int e_m1 = 0, e_m2 = 0;
  bit e_h1 = 0, e_h2 = 0;
  bit a1, a2, c1, c2, w2;
  int d, att, vic;

  task automatic model_apply();
    int vx, wd, mot;
    vx = m_vic2 ? int'(P2_X) : int'(P1_X);
    wd = (m_dir > 0) ? (BMAX - vx) : (vx - BMIN);
    if (wd < 0) wd = 0;
    if (wd < m_spd) begin
      mot = m_dir * wd;
      m_last = 1;
    end else begin
      mot = m_dir * m_spd;
      m_last = (m_spd == KB_E);
    end
    e_m1 = m_vic2 ? 0 : mot;
    e_m2 = m_vic2 ? mot : 0;
  endtask

  always @(posedge clk) begin
    if (Reset) begin
      m_live = 1;
      m_prev1 = 1; m_prev2 = 1; m_pend1 = 0; m_pend2 = 0;
      m_prio2 = 0; m_knock = 0; m_last = 0; m_vic2 = 0;
      m_lock = 0; m_spd = 0; m_dir = 0;
      e_m1 = 0; e_m2 = 0; e_h1 = 0; e_h2 = 0;
    end else begin
      a1 = m_pend1 || (P1_Punch && !m_prev1);
      a2 = m_pend2 || (P2_Punch && !m_prev2);
      m_prev1 = P1_Punch;
      m_prev2 = P2_Punch;
      m_pend1 = a1;
      m_pend2 = a2;
      e_h1 = 0; e_h2 = 0;
      if (frame_tick) begin
        m_pend1 = 0; m_pend2 = 0;
        if (m_knock) begin
          if (m_last) begin
            e_m1 = 0; e_m2 = 0;
            m_knock = 0;
            m_lock = LOCK_FRAMES;
          end else begin
            m_spd = m_spd - 1;
            model_apply();
          end
        end else if (m_lock > 0) begin
          m_lock = m_lock - 1;
        end else begin
          d = int'(P1_X) - int'(P2_X);
          if (d < 0) d = -d;
          c1 = a1 && (d <= REACH);
          c2 = a2 && (d <= REACH);
          if (c1 || c2) begin
            w2 = c2 && (!c1 || m_prio2);
            m_prio2 = !w2;
            e_h1 = !w2; e_h2 = w2;
            m_vic2 = !w2;
            att = w2 ? int'(P2_X) : int'(P1_X);
            vic = w2 ? int'(P1_X) : int'(P2_X);
            if (vic > att) m_dir = 1;
            else if (vic < att) m_dir = -1;
            else m_dir = m_vic2 ? 1 : -1;
            m_spd = KB_S;
            m_knock = 1;
            model_apply();
          end
        end
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("p1_motion", P1_X_Motion, e_m1);
      chk("p2_motion", P2_X_Motion, e_m2);
      chk("p1_hit", {31'd0, P1_Hit}, {31'd0, e_h1});
      chk("p2_hit", {31'd0, P2_Hit}, {31'd0, e_h2});
      chk("busy", {31'd0, busy}, (m_knock || m_lock > 0) ? 32'sd1 : 32'sd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic press(input bit p1, input bit p2);
    @(negedge clk) begin P1_Punch = p1; P2_Punch = p2; end
    @(negedge clk) begin P1_Punch = 1'b0; P2_Punch = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk) Reset = 1'b1;
    @(negedge clk) Reset = 1'b1;
    @(negedge clk) Reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'sd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    chk("rst_p1_mot", P1_X_Motion, 0);
    chk("rst_p2_mot", P2_X_Motion, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // Unclamped knockback of P2 by P1
    P1_X = 100; P2_X = 130;
    press(1, 0);
    tick();
    chk("t1_p1_hit", {31'd0, P1_Hit}, 1);
    chk("t1_p2_hit", {31'd0, P2_Hit}, 0);
    chk("t1_kb9", P2_X_Motion, 9);
    chk("t1_p1_still", P1_X_Motion, 0);
    for (int s = 8; s >= 4; s--) begin
      tick();
      chk("t1_kb", P2_X_Motion, s);
      chk("t1_hit_gone", {31'd0, P1_Hit}, 0);
    end
    tick();
    chk("t1_kb_end", P2_X_Motion, 0);
`ifdef FIGHT_ARB_COOLDOWN_EN
    chk("t1_busy_cool", {31'd0, busy}, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t1_cool_busy", {31'd0, busy}, (i < 8) ? 1 : 0);
    end
`else
    chk("t1_busy_done", {31'd0, busy}, 0);
`endif
    wait_idle();

    // Out of reach: no hit
    P1_X = 100; P2_X = 200;
    press(1, 1);
    tick();
    chk("t2_p1_hit", {31'd0, P1_Hit}, 0);
    chk("t2_p2_hit", {31'd0, P2_Hit}, 0);
    chk("t2_busy", {31'd0, busy}, 0);

    // Alternating priority after reset
    do_reset();
    P1_X = 100; P2_X = 130;
    press(1, 1);
    tick();
    chk("t3_p1_wins", {31'd0, P1_Hit}, 1);
    chk("t3_p2_loses", {31'd0, P2_Hit}, 0);
    wait_idle();
    press(1, 1);
    tick();
    chk("t3_p2_wins", {31'd0, P2_Hit}, 1);
    chk("t3_p1_loses", {31'd0, P1_Hit}, 0);
    chk("t3_p1_kb", P1_X_Motion, -9);
    wait_idle();

    // Wall clamp near right bound
    P1_X = 600; P2_X = 627;
    press(1, 0);
    tick();
    chk("t4_hit", {31'd0, P1_Hit}, 1);
    chk("t4_clamp", P2_X_Motion, 5);
    tick();
    chk("t4_zero", P2_X_Motion, 0);
`ifdef FIGHT_ARB_COOLDOWN_EN
    chk("t4_cool", {31'd0, busy}, 1);
    tick(); tick();
    press(1, 0);
    tick();
    chk("t5_cool_ignored", {31'd0, P1_Hit}, 0);
    chk("t5_cool_busy", {31'd0, busy}, 1);
    wait_idle();
    press(1, 0);
    tick();
    chk("t5_after_idle", {31'd0, P1_Hit}, 1);
`else
    chk("t4_idle", {31'd0, busy}, 0);
    press(1, 0);
    tick();
    chk("t5_hit", {31'd0, P1_Hit}, 1);
    press(1, 0);
    tick();
    chk("t5_knock_ignored", {31'd0, P1_Hit}, 0);
`endif
    wait_idle();

    // Reset in the third knockback frame with the button held
    P1_X = 100; P2_X = 130;
    @(negedge clk) P1_Punch = 1'b1;
    tick();
    chk("t6_hit", {31'd0, P1_Hit}, 1);
    tick(); tick();
    chk("t6_kb7", P2_X_Motion, 7);
    @(negedge clk) Reset = 1'b1;
    @(negedge clk) Reset = 1'b0;
    chk("t6_rst_m2", P2_X_Motion, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    tick();
    chk("t6_held_nohit", {31'd0, P1_Hit}, 0);
    tick();
    chk("t6_held_nohit2", {31'd0, P1_Hit}, 0);
    @(negedge clk) P1_Punch = 1'b0;
    press(1, 0);
    tick();
    chk("t6_repress_hit", {31'd0, P1_Hit}, 1);
    wait_idle();

    // Randomized traffic against the model
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (c % 20 == 0) begin
        b = int'($urandom_range(0, 660)) - 10;
        P1_X = b;
        P2_X = b + int'($urandom_range(0, 100)) - 50;
      end
      frame_tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) P1_Punch = ~P1_Punch;
      if ($urandom_range(0, 4) == 0) P2_Punch = ~P2_Punch;
      Reset = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk) begin
      Reset = 1'b0; frame_tick = 1'b0; P1_Punch = 1'b0; P2_Punch = 1'b0;
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
